// File: rtl/rle_fifo_arb.sv
// rle_fifo_arb: round-robin merge of two RLE (char, count) sources into one decode FIFO,
// sequenced as IDLE -> FILL -> DRAIN. Define RLE_FIFO_ARB_STATS_EN for grant/drop counters.

module rle_fifo_arb #(
   parameter int IDLE_TIMEOUT = 4,
   parameter int DW           = 8,
   parameter int CW           = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0,
   input  logic [DW-1:0] din0,
   input  logic [CW-1:0] cin0,
   output logic          gnt0,
   input  logic          req1,
   input  logic [DW-1:0] din1,
   input  logic [CW-1:0] cin1,
   output logic          gnt1,
   output logic          fifo_wr_en,
   output logic [DW-1:0] fifo_din,
   output logic [CW-1:0] fifo_cin,
   output logic          fifo_rd_en,
   input  logic          fifo_full,
   input  logic          fifo_empty,
   input  logic          sink_rdy,
   output logic [1:0]    phase
`ifdef RLE_FIFO_ARB_STATS_EN
   ,
   output logic [15:0]   stat_cnt0,
   output logic [15:0]   stat_cnt1,
   output logic [7:0]    drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] LP_TIMEOUT = 4'(IDLE_TIMEOUT);

   state_t     r_state, w_state_nxt;
   logic       r_rr_ptr, w_rr_nxt;
   logic [3:0] r_idle_cnt, w_idle_nxt, w_idle_inc;
   logic       w_any_req, w_any_gnt, w_zero_cnt;

   assign w_any_req = req0 | req1;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (r_state == ST_FILL && !fifo_full) begin
         if (req0 && req1) begin
            gnt0 = ~r_rr_ptr;
            gnt1 =  r_rr_ptr;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      fifo_din = '0;
      fifo_cin = '0;
      if (gnt0) begin
         fifo_din = din0;
         fifo_cin = cin0;
      end else if (gnt1) begin
         fifo_din = din1;
         fifo_cin = cin1;
      end
   end

   // Zero-count pairs are consumed (granted) but never reach the FIFO.
   assign w_any_gnt  = gnt0 | gnt1;
   assign w_zero_cnt = (fifo_cin == '0);
   assign fifo_wr_en = w_any_gnt & ~w_zero_cnt;
   assign fifo_rd_en = (r_state == ST_DRAIN) & sink_rdy & ~fifo_empty;
   assign phase      = r_state;

   always_comb begin
      w_rr_nxt = r_rr_ptr;
      if (gnt0) begin
         w_rr_nxt = 1'b1;
      end else if (gnt1) begin
         w_rr_nxt = 1'b0;
      end
   end

   assign w_idle_inc = (r_idle_cnt == LP_TIMEOUT) ? r_idle_cnt : r_idle_cnt + 4'd1;

   // Idle counter defaults to zero: it clears on any request and on every state exit.
   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = 4'd0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = ST_FILL;
            end else if (!fifo_empty) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_FILL: begin
            if (fifo_full) begin
               w_state_nxt = ST_DRAIN;
            end else if (!w_any_req) begin
               if (w_idle_inc == LP_TIMEOUT) begin
                  w_state_nxt = fifo_empty ? ST_IDLE : ST_DRAIN;
               end else begin
                  w_idle_nxt = w_idle_inc;
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= 1'b0;
         r_idle_cnt <= 4'd0;
      end else begin
         // NOTE: non-blocking so every register updates from the same pre-edge values.
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_idle_cnt <= w_idle_nxt;
      end
   end

`ifdef RLE_FIFO_ARB_STATS_EN
   logic [15:0] r_stat_cnt0, r_stat_cnt1;
   logic [7:0]  r_drop_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stat_cnt0 <= 16'd0;
         r_stat_cnt1 <= 16'd0;
         r_drop_cnt  <= 8'd0;
      end else begin
         if (gnt0 && r_stat_cnt0 != 16'hFFFF) r_stat_cnt0 <= r_stat_cnt0 + 16'd1;
         if (gnt1 && r_stat_cnt1 != 16'hFFFF) r_stat_cnt1 <= r_stat_cnt1 + 16'd1;
         if (w_any_gnt && w_zero_cnt && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign stat_cnt0 = r_stat_cnt0;
   assign stat_cnt1 = r_stat_cnt1;
   assign drop_cnt  = r_drop_cnt;
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_rle_fifo_arb.sv
// Testbench for rle_fifo_arb: directed vector table, hand sequences for the multi-cycle
// corners, and randomized traffic against a queue-based FIFO/scheduler reference model.

module tb_rle_fifo_arb;

   localparam int IDLE_T = 4;
   localparam int NV     = 17;

   logic       CLK, RST;
   logic       req0, req1, gnt0, gnt1;
   logic [7:0] din0, din1, fifo_din;
   logic [3:0] cin0, cin1, fifo_cin;
   logic       fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty, sink_rdy;
   logic [1:0] phase;
`ifdef RLE_FIFO_ARB_STATS_EN
   logic [15:0] stat_cnt0, stat_cnt1;
   logic [7:0]  drop_cnt;
`endif

   rle_fifo_arb #(.IDLE_TIMEOUT(IDLE_T), .DW(8), .CW(4)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .din0(din0), .cin0(cin0), .gnt0(gnt0),
      .req1(req1), .din1(din1), .cin1(cin1), .gnt1(gnt1),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_cin(fifo_cin),
      .fifo_rd_en(fifo_rd_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .sink_rdy(sink_rdy), .phase(phase)
`ifdef RLE_FIFO_ARB_STATS_EN
      , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .drop_cnt(drop_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [7:0] ch;
      logic [3:0] cnt;
   } pair_t;

   // Directed vector: inputs plus expected {phase, gnt0, gnt1, wr_en, rd_en, din, cin}.
   typedef struct {
      logic        r0, r1;
      logic [7:0]  d1;
      logic [3:0]  c1;
      logic        full, empty, srdy;
      logic [17:0] exp;
   } vec_t;

   int    n_checks = 0;
   int    n_errors = 0;
   pair_t src0_q[$], src1_q[$], fq[$];
   int    depth = 4;
   int    m_phase, m_rr, m_idle, m_win;
   int    m_stat0, m_stat1, m_drop;
   int    d_writes, d_reads;
   vec_t  vt[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] pk(int ph, int g0, int g1, int we, int rd, int din, int cin);
      return {2'(ph), 1'(g0), 1'(g1), 1'(we), 1'(rd), 8'(din), 4'(cin)};
   endfunction

   function automatic vec_t mkv(int r0, int r1, int d1, int c1, int full, int empty, int srdy,
                                logic [17:0] exp);
      vec_t v;
      v.r0 = 1'(r0);    v.r1 = 1'(r1);
      v.d1 = 8'(d1);    v.c1 = 4'(c1);
      v.full = 1'(full); v.empty = 1'(empty); v.srdy = 1'(srdy);
      v.exp = exp;
      return v;
   endfunction

   function automatic logic [17:0] dut_vec();
      return {phase, gnt0, gnt1, fifo_wr_en, fifo_rd_en, fifo_din, fifo_cin};
   endfunction

   function automatic pair_t mkp(int ch, int cnt);
      pair_t p;
      p.ch  = 8'(ch);
      p.cnt = 4'(cnt);
      return p;
   endfunction

   task automatic model_clear();
      m_phase = 0; m_rr = 0; m_idle = 0; m_win = -1;
      m_stat0 = 0; m_stat1 = 0; m_drop = 0;
   endtask

   // Inputs follow the source queues and the modelled FIFO occupancy.
   task automatic drive();
      req0 = (src0_q.size() != 0);
      din0 = req0 ? src0_q[0].ch  : 8'd0;
      cin0 = req0 ? src0_q[0].cnt : 4'd0;
      req1 = (src1_q.size() != 0);
      din1 = req1 ? src1_q[0].ch  : 8'd0;
      cin1 = req1 ? src1_q[0].cnt : 4'd0;
      fifo_full  = (fq.size() >= depth);
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic model_exp(output logic [17:0] v);
      int w;
      int d, c;
      w = -1;
      if (m_phase == 1 && !fifo_full) begin
         if (req0 && req1) w = m_rr;
         else if (req0)    w = 0;
         else if (req1)    w = 1;
      end
      d = (w == 0) ? int'(din0) : (w == 1) ? int'(din1) : 0;
      c = (w == 0) ? int'(cin0) : (w == 1) ? int'(cin1) : 0;
      m_win = w;
      v = pk(m_phase, int'(w == 0), int'(w == 1), int'(w >= 0 && c != 0),
             int'(m_phase == 2 && sink_rdy && !fifo_empty), d, c);
   endtask

   task automatic model_step(input logic [17:0] ev);
      if (ev[13]) fq.push_back(mkp(int'(ev[11:4]), int'(ev[3:0])));
      if (ev[12]) void'(fq.pop_front());
      if (m_win >= 0) begin
         if (ev[3:0] == 4'd0 && m_drop < 255) m_drop++;
         m_rr = 1 - m_win;
      end
      if (m_win == 0) begin
         void'(src0_q.pop_front());
         if (m_stat0 < 65535) m_stat0++;
      end
      if (m_win == 1) begin
         void'(src1_q.pop_front());
         if (m_stat1 < 65535) m_stat1++;
      end
      case (m_phase)
         0: begin
            if (req0 || req1) m_phase = 1;
            else if (!fifo_empty) m_phase = 2;
         end
         1: begin
            if (fifo_full) begin
               m_phase = 2;
               m_idle  = 0;
            end else if (req0 || req1) begin
               m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle >= IDLE_T) begin
                  m_phase = fifo_empty ? 0 : 2;
                  m_idle  = 0;
               end
            end
         end
         default: if (fifo_empty) m_phase = 0;
      endcase
   endtask

   // One clock: sample at the falling edge, advance the model at the rising edge.
   task automatic tick(input string name);
      logic [17:0] ev;
      drive();
      @(negedge CLK);
      model_exp(ev);
      check(name, 32'(dut_vec()), 32'(ev));
      if (fifo_wr_en) d_writes++;
      if (fifo_rd_en) d_reads++;
      @(posedge CLK);
      model_step(ev);
      #1;
      drive();
   endtask

   task automatic run_until_phase(input int p, input int budget, input string name);
      int n;
      n = 0;
      while (m_phase != p && n < budget) begin
         tick(name);
         n++;
      end
      check({name, "_phase"}, 32'(phase), 32'(p));
   endtask

   task automatic do_reset();
      RST = 1'b1;
      src0_q.delete();
      src1_q.delete();
      fq.delete();
      model_clear();
      sink_rdy = 1'b0;
      drive();
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   function automatic pair_t rand_pair();
      return mkp(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
   endfunction

   initial begin
      int quiet;

      vt[0]  = mkv(1, 1,  98, 2, 0, 1, 1, pk(0, 0, 0, 0, 0,   0, 0));
      vt[1]  = mkv(1, 1,  98, 2, 0, 1, 1, pk(1, 1, 0, 1, 0,  97, 3));
      vt[2]  = mkv(1, 1,  98, 2, 0, 1, 1, pk(1, 0, 1, 1, 0,  98, 2));
      vt[3]  = mkv(1, 1,  98, 2, 0, 1, 1, pk(1, 1, 0, 1, 0,  97, 3));
      vt[4]  = mkv(0, 1, 103, 0, 0, 1, 1, pk(1, 0, 1, 0, 0, 103, 0));
      vt[5]  = mkv(1, 1,  98, 2, 0, 1, 1, pk(1, 1, 0, 1, 0,  97, 3));
      vt[6]  = mkv(1, 1,  98, 2, 0, 1, 1, pk(1, 0, 1, 1, 0,  98, 2));
      vt[7]  = mkv(1, 1,  98, 2, 1, 0, 1, pk(1, 0, 0, 0, 0,   0, 0));
      vt[8]  = mkv(1, 1,  98, 2, 1, 0, 1, pk(2, 0, 0, 0, 1,   0, 0));
      vt[9]  = mkv(1, 1,  98, 2, 0, 0, 0, pk(2, 0, 0, 0, 0,   0, 0));
      vt[10] = mkv(1, 1,  98, 2, 0, 1, 1, pk(2, 0, 0, 0, 0,   0, 0));
      vt[11] = mkv(1, 1,  98, 2, 0, 1, 1, pk(0, 0, 0, 0, 0,   0, 0));
      vt[12] = mkv(0, 0,   0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0,   0, 0));
      vt[13] = mkv(0, 0,   0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0,   0, 0));
      vt[14] = mkv(0, 0,   0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0,   0, 0));
      vt[15] = mkv(0, 0,   0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0,   0, 0));
      vt[16] = mkv(0, 0,   0, 0, 0, 1, 1, pk(0, 0, 0, 0, 0,   0, 0));

      d_writes = 0;
      d_reads  = 0;
      do_reset();

      for (int i = 0; i < NV; i++) begin
         req0 = vt[i].r0;  din0 = 8'd97;    cin0 = 4'd3;
         req1 = vt[i].r1;  din1 = vt[i].d1; cin1 = vt[i].c1;
         fifo_full = vt[i].full; fifo_empty = vt[i].empty; sink_rdy = vt[i].srdy;
         @(negedge CLK);
         check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vt[i].exp));
         @(posedge CLK);
         #1;
      end
`ifdef RLE_FIFO_ARB_STATS_EN
      check("vec_stat0", 32'(stat_cnt0), 32'd3);
      check("vec_stat1", 32'(stat_cnt1), 32'd3);
      check("vec_drop",  32'(drop_cnt),  32'd1);
`endif

      // Reset held with a pending request, then released.
      RST = 1'b1;
      src0_q.delete(); src1_q.delete(); fq.delete();
      model_clear();
      src0_q.push_back(mkp(99, 1));
      sink_rdy = 1'b1;
      drive();
      #2;
      check("rst_hold", {28'd0, phase, gnt0, fifo_wr_en}, 32'd0);
      @(posedge CLK);
      #1;
      check("rst_hold_edge", {28'd0, phase, gnt0, fifo_wr_en}, 32'd0);
      RST = 1'b0;
      tick("rst_rel");
      check("rst_release_phase", 32'(phase), 32'd1);

      // Fill a depth-4 FIFO from source 0 until full, then drain it.
      do_reset();
      depth = 4;
      src0_q.push_back(mkp(99, 1));
      src0_q.push_back(mkp(100, 2));
      src0_q.push_back(mkp(101, 5));
      src0_q.push_back(mkp(102, 2));
      src0_q.push_back(mkp(104, 3));
      d_writes = 0;
      run_until_phase(2, 20, "fill");
      check("fill_writes", 32'(d_writes), 32'd4);
      check("drain_req_wait", {30'd0, req0, gnt0}, 32'd2);
      tick("drain_hold");
      check("drain_hold_phase", 32'(phase), 32'd2);
      sink_rdy = 1'b1;
      d_reads = 0;
      run_until_phase(0, 20, "drain");
      check("drain_reads", 32'(d_reads), 32'd4);
      tick("refill");
      check("refill_phase", 32'(phase), 32'd1);

      // Zero-count pair: granted and dropped; nothing written so timeout returns to IDLE.
      do_reset();
      src1_q.push_back(mkp(103, 0));
      sink_rdy = 1'b1;
      tick("zc_idle");
      check("zc_strobe", {19'd0, gnt1, fifo_wr_en, fifo_din, fifo_cin}, {19'd0, 1'b1, 1'b0, 8'd103, 4'd0});
      tick("zc_grant");
      for (int i = 0; i < IDLE_T - 1; i++) tick("zc_quiet");
      check("zc_quiet_phase", 32'(phase), 32'd1);
      tick("zc_quiet_last");
      check("zc_timeout_idle", 32'(phase), 32'd0);
`ifdef RLE_FIFO_ARB_STATS_EN
      check("zc_stat1", 32'(stat_cnt1), 32'd1);
      check("zc_drop",  32'(drop_cnt),  32'd1);
`endif

      // Timeout after one written pair goes FILL -> DRAIN, then back to IDLE.
      do_reset();
      src0_q.push_back(mkp(105, 4));
      tick("to_idle");
      tick("to_grant");
      for (int i = 0; i < IDLE_T - 1; i++) tick("to_quiet");
      check("to_quiet_phase", 32'(phase), 32'd1);
      tick("to_quiet_last");
      check("to_drain_phase", 32'(phase), 32'd2);
      sink_rdy = 1'b1;
      tick("to_read");
      tick("to_empty");
      check("to_done_phase", 32'(phase), 32'd0);

      // Asynchronous reset between edges while a read is in progress.
      do_reset();
      src0_q.push_back(mkp(106, 2));
      run_until_phase(2, 20, "ar");
      sink_rdy = 1'b1;
      #1;
      check("ar_rd_before", 32'(fifo_rd_en), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      check("ar_abort", {27'd0, phase, fifo_rd_en, fifo_wr_en, gnt0}, 32'd0);

      // Randomized traffic with quiet windows and a stalling sink.
      do_reset();
      depth = 4;
      quiet = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (quiet > 0) begin
            quiet--;
         end else begin
            if ($urandom_range(0, 39) == 0) quiet = int'($urandom_range(4, 9));
            if (src0_q.size() < 2 && $urandom_range(0, 2) != 0) src0_q.push_back(rand_pair());
            if (src1_q.size() < 2 && $urandom_range(0, 2) != 0) src1_q.push_back(rand_pair());
         end
         sink_rdy = ($urandom_range(0, 3) != 0);
         tick("rand");
      end
`ifdef RLE_FIFO_ARB_STATS_EN
      check("rand_stat0", 32'(stat_cnt0), 32'(m_stat0));
      check("rand_stat1", 32'(stat_cnt1), 32'(m_stat1));
      check("rand_drop",  32'(drop_cnt),  32'(m_drop));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
